// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: job sequencer for one parallel_pe dot-product engine (SRAM reads, pe ctl/vld, result FIFO).
// Optional feature macro STALL_CNT_EN adds a saturating stall_cnt output.
module pe_seq_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 12,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_vec_len,
  input  logic [CNT_W-1:0]  cfg_out_num,
  input  logic [ADDR_W-1:0] cfg_nrn_base,
  input  logic [ADDR_W-1:0] cfg_wt_base,
  output logic              busy,
  output logic              done,
  output logic              nrn_rd_en,
  output logic [ADDR_W-1:0] nrn_rd_addr,
  input  logic [511:0]      nrn_rd_data,
  output logic              wt_rd_en,
  output logic [ADDR_W-1:0] wt_rd_addr,
  input  logic [511:0]      wt_rd_data,
  output logic [511:0]      pe_neuron,
  output logic [511:0]      pe_weight,
  output logic [1:0]        pe_ctl,
  output logic              pe_vld,
  input  logic [31:0]       pe_result,
  input  logic              pe_vld_o,
  output logic              res_valid,
  output logic [31:0]       res_data,
`ifdef STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  input  logic              res_ready
);

  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int OCC_W = $clog2(RES_DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(RES_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, k_q;
  logic [CNT_W-1:0]  out_q, o_q;
  logic [ADDR_W-1:0] nrn_base_q, wt_addr_q;
  logic [OCC_W-1:0]  used_q, used_d, fifo_cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [31:0]       fifo_mem [RES_DEPTH];

  logic start_acc, cfg_zero;
  logic k_first, k_last, o_last, credit_ok;
  logic issue, job_last, reserve;
  logic push, pop, fifo_wr, fifo_rd, fifo_empty;
  logic       vld_p1;
  logic [1:0] ctl_p1;
  logic       last_p2;

  assign start_acc  = (state_q == S_IDLE) && start;
  assign cfg_zero   = (cfg_vec_len == '0) || (cfg_out_num == '0);
  assign k_first    = (k_q == '0);
  assign k_last     = (k_q == len_q - LEN_W'(1));
  assign o_last     = (o_q == out_q - CNT_W'(1));

  // used_q counts reserved-plus-occupied result slots; only a new output (k=0) may stall on it.
  assign credit_ok  = (used_q != FULL);
  assign issue      = (state_q == S_RUN) && (!k_first || credit_ok);
  assign job_last   = issue && k_last && o_last;
  assign reserve    = issue && k_first;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = pe_vld_o && last_p2;
  assign pop        = res_valid && res_ready;
  assign fifo_wr    = push && !(fifo_empty && pop);
  assign fifo_rd    = pop && !fifo_empty;
  assign used_d     = used_q + OCC_W'(reserve) - OCC_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = cfg_zero ? S_DONE : S_RUN;
      S_RUN:   if (job_last) state_d = S_DRAIN;
      S_DRAIN: if (used_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    nrn_rd_en   = issue;
    wt_rd_en    = issue;
    nrn_rd_addr = '0;
    wt_rd_addr  = '0;
    if (state_q == S_RUN) begin
      nrn_rd_addr = nrn_base_q + ADDR_W'(k_q);
      wt_rd_addr  = wt_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (start_acc) begin
      len_q      <= cfg_vec_len;
      out_q      <= cfg_out_num;
      nrn_base_q <= cfg_nrn_base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      o_q       <= '0;
      wt_addr_q <= '0;
      used_q    <= '0;
    end else begin
      used_q <= used_d;
      if (start_acc) begin
        k_q       <= '0;
        o_q       <= '0;
        wt_addr_q <= cfg_wt_base;
      end else if (issue) begin
        wt_addr_q <= wt_addr_q + ADDR_W'(1);
        if (k_last) begin
          k_q <= '0;
          o_q <= o_q + CNT_W'(1);
        end else begin
          k_q <= k_q + LEN_W'(1);
        end
      end
    end
  end

  // Stage p1: SRAM data arrives; ctl/vld delayed one cycle to sit beside it at the pe.
  // Stage p2: pe result strobe; last_p2 marks the chunk that closes an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      ctl_p1  <= 2'b00;
      last_p2 <= 1'b0;
    end else begin
      vld_p1  <= issue;
      ctl_p1  <= issue ? {k_last, !k_first} : 2'b00;
      last_p2 <= vld_p1 && ctl_p1[1];
    end
  end

  assign pe_vld    = vld_p1;
  assign pe_ctl    = ctl_p1;
  assign pe_neuron = nrn_rd_data;
  assign pe_weight = wt_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_q + OCC_W'(fifo_wr) - OCC_W'(fifo_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q] <= pe_result;
  end

  // An empty FIFO forwards a fresh result straight to the stream in the push cycle.
  assign res_valid = !fifo_empty || push;
  assign res_data  = !fifo_empty ? fifo_mem[rd_ptr_q] : (push ? pe_result : 32'd0);

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_cnt_q == FULL)));

`ifdef STALL_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic stall;
  assign stall = (state_q == S_RUN) && k_first && !credit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         stall_cnt <= 32'd0;
    else if (start_acc) stall_cnt <= 32'd0;
    else if (stall)     stall_cnt <= sat_inc32(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with behavioural SRAM and pe models.
module tb_pe_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   cfg_vec_len;
  logic [11:0]  cfg_out_num;
  logic [9:0]   cfg_nrn_base;
  logic [9:0]   cfg_wt_base;
  logic         busy, done;
  logic         nrn_rd_en, wt_rd_en;
  logic [9:0]   nrn_rd_addr, wt_rd_addr;
  logic [511:0] nrn_rd_data, wt_rd_data;
  logic [511:0] pe_neuron, pe_weight;
  logic [1:0]   pe_ctl;
  logic         pe_vld;
  logic [31:0]  pe_result;
  logic         pe_vld_o;
  logic         res_valid;
  logic [31:0]  res_data;
  logic         res_ready;
`ifdef STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_n = 0;
  int done_cyc = 0;
  int last_pop_cyc = 0;
  logic [9:0]  nrn_q[$];
  logic [9:0]  wt_q[$];
  logic [1:0]  ctl_q[$];
  logic [31:0] res_q[$];

  pe_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_vec_len(cfg_vec_len), .cfg_out_num(cfg_out_num),
    .cfg_nrn_base(cfg_nrn_base), .cfg_wt_base(cfg_wt_base),
    .busy(busy), .done(done),
    .nrn_rd_en(nrn_rd_en), .nrn_rd_addr(nrn_rd_addr), .nrn_rd_data(nrn_rd_data),
    .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
    .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_ctl(pe_ctl), .pe_vld(pe_vld),
    .pe_result(pe_result), .pe_vld_o(pe_vld_o),
    .res_valid(res_valid), .res_data(res_data),
`ifdef STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // SRAM word at address a: lane0 = a+1, lane15 = 2, other lanes 0.
  function automatic logic [511:0] word(input logic [9:0] a);
    logic [511:0] w;
    w = '0;
    w[31:0] = {22'd0, a} + 32'd1;
    w[511:480] = 32'd2;
    return w;
  endfunction

  function automatic logic [31:0] dot(input logic [511:0] x, input logic [511:0] y);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + x[32*i +: 32] * y[32*i +: 32];
    return s;
  endfunction

  always @(posedge clk) begin
    if (nrn_rd_en) nrn_rd_data <= word(nrn_rd_addr);
    if (wt_rd_en)  wt_rd_data  <= word(wt_rd_addr);
  end

  logic [31:0] psum;
  logic        vld_o_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum    <= 32'd0;
      vld_o_r <= 1'b0;
    end else begin
      vld_o_r <= pe_vld;
      if (pe_vld) psum <= (pe_ctl[0] ? psum : 32'd0) + dot(pe_neuron, pe_weight);
    end
  end
  assign pe_result = psum;
  assign pe_vld_o  = vld_o_r;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (nrn_rd_en) nrn_q.push_back(nrn_rd_addr);
      if (wt_rd_en)  wt_q.push_back(wt_rd_addr);
      if (pe_vld)    ctl_q.push_back(pe_ctl);
      if (res_valid && res_ready) begin
        res_q.push_back(res_data);
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    nrn_q.delete(); wt_q.delete(); ctl_q.delete(); res_q.delete();
    done_n = 0;
  endtask

  task automatic start_job(input int len, input int outs, input int nb, input int wb);
    cfg_vec_len  = 8'(len);
    cfg_out_num  = 12'(outs);
    cfg_nrn_base = 10'(nb);
    cfg_wt_base  = 10'(wb);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout done=%0b after %0d cycles, expected 1", name, done, n);
    end
    tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    cfg_vec_len = '0; cfg_out_num = '0; cfg_nrn_base = '0; cfg_wt_base = '0;
    #1;
    checks++;
    if ({busy, done, nrn_rd_en, wt_rd_en, pe_vld, res_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000", {busy, done, nrn_rd_en, wt_rd_en, pe_vld, res_valid});
    end
    checks++;
    if ({nrn_rd_addr, wt_rd_addr, pe_ctl} !== 22'd0) begin
      errors++;
      $display("FAIL reset_addr_ctl got %h/%h/%b exp 0", nrn_rd_addr, wt_rd_addr, pe_ctl);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checks++;
    if ({busy, done, nrn_rd_en, pe_vld, res_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release got %b exp 00000", {busy, done, nrn_rd_en, pe_vld, res_valid});
    end
  endtask

  task automatic test_basic();
    int exp_nrn[6] = '{0, 1, 2, 0, 1, 2};
    int exp_wt[6]  = '{16, 17, 18, 19, 20, 21};
    int exp_ctl[6] = '{0, 1, 3, 0, 1, 3};
    int exp_res[2] = '{122, 140};
    clear_logs();
    res_ready = 1'b1;
    start_job(3, 2, 0, 16);
    wait_done("basic", 200);
    checks++;
    if (nrn_q.size() !== 6 || wt_q.size() !== 6 || ctl_q.size() !== 6) begin
      errors++;
      $display("FAIL basic_issue_count got %0d/%0d/%0d exp 6", nrn_q.size(), wt_q.size(), ctl_q.size());
    end
    for (int i = 0; i < 6 && i < nrn_q.size() && i < wt_q.size() && i < ctl_q.size(); i++) begin
      checks++;
      if (int'(nrn_q[i]) !== exp_nrn[i] || int'(wt_q[i]) !== exp_wt[i] || int'(ctl_q[i]) !== exp_ctl[i]) begin
        errors++;
        $display("FAIL basic_chunk[%0d] got nrn=%0d wt=%0d ctl=%0d exp nrn=%0d wt=%0d ctl=%0d",
                 i, nrn_q[i], wt_q[i], ctl_q[i], exp_nrn[i], exp_wt[i], exp_ctl[i]);
      end
    end
    checks++;
    if (res_q.size() !== 2) begin
      errors++;
      $display("FAIL basic_res_count got %0d exp 2", res_q.size());
    end
    for (int i = 0; i < 2 && i < res_q.size(); i++) begin
      checks++;
      if (res_q[i] !== 32'(exp_res[i])) begin
        errors++;
        $display("FAIL basic_res[%0d] got %0d exp %0d", i, res_q[i], exp_res[i]);
      end
    end
    checks++;
    if (done_n !== 1 || done_cyc !== last_pop_cyc + 1) begin
      errors++;
      $display("FAIL basic_done got pulses=%0d at %0d exp 1 at %0d", done_n, done_cyc, last_pop_cyc + 1);
    end
  endtask

  task automatic test_single_chunk();
    int exp_res[4] = '{610, 616, 622, 628};
    clear_logs();
    res_ready = 1'b1;
    start_job(1, 4, 5, 100);
    wait_done("single", 200);
    checks++;
    if (ctl_q.size() !== 4 || res_q.size() !== 4) begin
      errors++;
      $display("FAIL single_count got ctl=%0d res=%0d exp 4", ctl_q.size(), res_q.size());
    end
    for (int i = 0; i < 4 && i < ctl_q.size() && i < res_q.size(); i++) begin
      checks++;
      if (ctl_q[i] !== 2'b10 || res_q[i] !== 32'(exp_res[i])) begin
        errors++;
        $display("FAIL single[%0d] got ctl=%b res=%0d exp ctl=10 res=%0d", i, ctl_q[i], res_q[i], exp_res[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    res_ready = 1'b0;
    start_job(1, 8, 0, 0);
    tick(22);
    checks++;
    if (nrn_q.size() !== 4) begin
      errors++;
      $display("FAIL bp_issues_before_pop got %0d exp 4", nrn_q.size());
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_head got valid=%0b data=%0d busy=%0b exp 1/5/1", res_valid, res_data, busy);
    end
    res_ready = 1'b1;
    wait_done("bp", 300);
    checks++;
    if (res_q.size() !== 8 || nrn_q.size() !== 8) begin
      errors++;
      $display("FAIL bp_count got res=%0d issues=%0d exp 8", res_q.size(), nrn_q.size());
    end
    for (int i = 0; i < 8 && i < res_q.size(); i++) begin
      checks++;
      if (res_q[i] !== 32'(i + 5)) begin
        errors++;
        $display("FAIL bp_res[%0d] got %0d exp %0d", i, res_q[i], i + 5);
      end
    end
`ifdef STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd19) begin
      errors++;
      $display("FAIL bp_stall_cnt got %0d exp 19", stall_cnt);
    end
`endif
  endtask

  task automatic test_zero_job();
    int lens[2] = '{2, 0};
    int outs[2] = '{0, 3};
    for (int j = 0; j < 2; j++) begin
      clear_logs();
      start_job(lens[j], outs[j], 0, 0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL zero%0d_done got done=%0b busy=%0b exp 1/1", j, done, busy);
      end
      tick(1);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || nrn_q.size() !== 0 || wt_q.size() !== 0) begin
        errors++;
        $display("FAIL zero%0d_after got done=%0b busy=%0b rd=%0d exp 0/0/0", j, done, busy, nrn_q.size());
      end
    end
  endtask

  task automatic test_start_while_busy();
    clear_logs();
    res_ready = 1'b1;
    start_job(2, 1, 10, 20);
    cfg_vec_len = 8'd1; cfg_out_num = 12'd3; cfg_nrn_base = 10'd50; cfg_wt_base = 10'd60;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("busy_start", 200);
    tick(3);
    checks++;
    if (nrn_q.size() !== 2 || wt_q.size() !== 2 || res_q.size() !== 1 || done_n !== 1) begin
      errors++;
      $display("FAIL busy_start_count got rd=%0d/%0d res=%0d done=%0d exp 2/2/1/1",
               nrn_q.size(), wt_q.size(), res_q.size(), done_n);
    end
    if (nrn_q.size() == 2 && wt_q.size() == 2 && res_q.size() == 1) begin
      checks++;
      if (nrn_q[0] !== 10'd10 || nrn_q[1] !== 10'd11 || wt_q[0] !== 10'd20 || wt_q[1] !== 10'd21 ||
          res_q[0] !== 32'd503) begin
        errors++;
        $display("FAIL busy_start_data got %0d,%0d/%0d,%0d res=%0d exp 10,11/20,21 res=503",
                 nrn_q[0], nrn_q[1], wt_q[0], wt_q[1], res_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    clear_logs();
    res_ready = 1'b1;
    start_job(4, 4, 0, 0);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, nrn_rd_en, wt_rd_en, pe_vld, res_valid} !== 6'b0 ||
        {nrn_rd_addr, wt_rd_addr, pe_ctl} !== 22'd0) begin
      errors++;
      $display("FAIL midrst_outputs got %b addr=%0d/%0d ctl=%b exp all 0",
               {busy, done, nrn_rd_en, wt_rd_en, pe_vld, res_valid}, nrn_rd_addr, wt_rd_addr, pe_ctl);
    end
    tick(2);
    checks++;
    if (done_n !== 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_done got pulses=%0d done=%0b exp 0", done_n, done);
    end
    rst_n = 1'b1;
    tick(1);
    clear_logs();
    start_job(2, 2, 3, 7);
    wait_done("midrst_rerun", 200);
    checks++;
    if (res_q.size() !== 2) begin
      errors++;
      $display("FAIL midrst_res_count got %0d exp 2", res_q.size());
    end else begin
      checks++;
      if (res_q[0] !== 32'd85 || res_q[1] !== 32'd103) begin
        errors++;
        $display("FAIL midrst_res got %0d,%0d exp 85,103", res_q[0], res_q[1]);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_nrn[4] = '{1022, 1023, 0, 1};
    clear_logs();
    res_ready = 1'b1;
    start_job(4, 1, 1022, 1020);
    wait_done("wrap", 200);
    checks++;
    if (nrn_q.size() !== 4) begin
      errors++;
      $display("FAIL wrap_count got %0d exp 4", nrn_q.size());
    end
    for (int i = 0; i < 4 && i < nrn_q.size(); i++) begin
      checks++;
      if (int'(nrn_q[i]) !== exp_nrn[i]) begin
        errors++;
        $display("FAIL wrap_nrn[%0d] got %0d exp %0d", i, nrn_q[i], exp_nrn[i]);
      end
    end
    checks++;
    if (res_q.size() !== 1 || res_q[0] !== 32'd2094098) begin
      errors++;
      $display("FAIL wrap_res got n=%0d first=%0d exp 1 x 2094098", res_q.size(),
               (res_q.size() > 0) ? res_q[0] : 32'd0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_chunk();
    test_backpressure();
    test_zero_job();
    test_start_while_busy();
    test_reset_mid_run();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
